// File: rtl/ri_context_sequencer.sv
// JPEG-LS run-interruption context sequencer: owns contexts 365/366, searches k, maps Errval, updates A/N/Nn.
// Define RI_KFAST_EN to replace the iterative k search with a single-cycle priority search.
module ri_context_sequencer #(
    parameter int A_length    = 16,
    parameter int N_length    = 7,
    parameter int temp_length = 17,
    parameter int k_length    = 5,
    parameter int err_length  = 9,
    parameter int mode_length = 2,
    parameter int RESET_N     = 64,
    parameter int A_INIT      = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [mode_length-1:0]  mode,
    input  logic                    ri_start,
    input  logic                    ri_type,
    output logic                    busy,
    output logic [temp_length-1:0]  temp,
    output logic                    k_valid,
    output logic [k_length-1:0]     k,
    input  logic                    err_valid,
    input  logic [err_length-1:0]   errval,
    output logic                    emerr_valid,
    output logic [err_length:0]     emerrval,
    output logic                    map_bit
);
    localparam int EW    = err_length + 1;
    localparam int CMP_W = temp_length + N_length + (2 ** k_length);
    localparam logic [k_length-1:0] K_MAX = {k_length{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SELECT   = 3'd1,
        ST_K_SEARCH = 3'd2,
        ST_WAIT_ERR = 3'd3,
        ST_UPDATE   = 3'd4
    } state_t;

    state_t state_r;
    state_t state_next_s;

    logic [A_length-1:0]    a_r  [0:1];
    logic [N_length-1:0]    n_r  [0:1];
    logic [N_length-1:0]    nn_r [0:1];
    logic                   type_r;
    logic [temp_length-1:0] temp_r;
    logic [k_length-1:0]    k_r;
    logic                   k_valid_r;
    logic                   emerr_valid_r;
    logic                   busy_r;
    logic [EW-1:0]          emerrval_r;
    logic                   map_r;
    logic                   err_neg_r;

    logic [A_length-1:0]    a_act_s;
    logic [N_length-1:0]    n_act_s;
    logic [N_length-1:0]    nn_act_s;
    logic [temp_length-1:0] temp_sel_s;
    logic                   k_done_s;
    logic [k_length-1:0]    k_next_s;
    logic                   busy_s;
    logic                   k_valid_s;
    logic                   emerr_valid_s;
    logic                   capture_s;
    logic                   err_take_s;
    logic                   ctx_upd_s;

    assign a_act_s  = a_r[type_r];
    assign n_act_s  = n_r[type_r];
    assign nn_act_s = nn_r[type_r];

    // Context-dependent auxiliary value for the Golomb parameter search
    always_comb begin
        temp_sel_s = temp_length'(a_act_s);
        if (type_r) begin
            temp_sel_s = temp_length'(a_act_s) + temp_length'(n_act_s >> 1);
        end else begin
            temp_sel_s = temp_length'(a_act_s);
        end
    end

`ifdef RI_KFAST_EN
    logic [k_length-1:0] k_fast_s;

    // Descending scan so the smallest satisfying k wins
    always_comb begin
        k_fast_s = K_MAX;
        for (int i = (2 ** k_length) - 1; i >= 0; i--) begin
            k_fast_s = ((CMP_W'(n_act_s) << i) >= CMP_W'(temp_r)) ? k_length'(i) : k_fast_s;
        end
    end

    assign k_done_s = 1'b1;
    assign k_next_s = k_fast_s;
`else
    logic [CMP_W-1:0] n_shift_s;
    logic             k_hit_s;

    assign n_shift_s = CMP_W'(n_act_s) << k_r;
    assign k_hit_s   = n_shift_s >= CMP_W'(temp_r);
    assign k_done_s  = k_hit_s || (k_r == K_MAX);
    assign k_next_s  = k_done_s ? k_r : k_r + k_length'(1);
`endif

    logic                  err_neg_s;
    logic                  err_pos_s;
    logic [err_length-1:0] err_abs_s;
    logic [N_length:0]     nn2_s;
    logic [N_length:0]     n_ext_s;
    logic                  map_s;
    logic [EW-1:0]         emerr_s;

    assign err_neg_s = errval[err_length-1];
    assign err_pos_s = !err_neg_s && (errval != {err_length{1'b0}});
    assign err_abs_s = err_neg_s ? (~errval + err_length'(1)) : errval;
    assign nn2_s     = {nn_act_s, 1'b0};
    assign n_ext_s   = {1'b0, n_act_s};
    assign map_s     = ((k_r == {k_length{1'b0}}) && err_pos_s && (nn2_s < n_ext_s))
                    || (err_neg_s && (nn2_s >= n_ext_s))
                    || (err_neg_s && (k_r != {k_length{1'b0}}));
    assign emerr_s   = {err_abs_s, 1'b0} - EW'(type_r) - EW'(map_s);

    logic [EW:0]         inc_s;
    logic [A_length:0]   a_sum_s;
    logic [A_length-1:0] a_add_s;
    logic [N_length-1:0] nn_inc_s;
    logic                halve_s;
    logic [A_length-1:0] a_new_s;
    logic [N_length-1:0] n_new_s;
    logic [N_length-1:0] nn_new_s;

    assign inc_s    = ({1'b0, emerrval_r} + (EW + 1)'(1) - (EW + 1)'(type_r)) >> 1;
    assign a_sum_s  = {1'b0, a_act_s} + (A_length + 1)'(inc_s);
    assign a_add_s  = a_sum_s[A_length] ? {A_length{1'b1}} : a_sum_s[A_length-1:0];
    assign nn_inc_s = nn_act_s + N_length'(err_neg_r);
    assign halve_s  = (n_act_s == N_length'(RESET_N));

    // Post-update context: halving acts on the post-add A and post-increment Nn
    always_comb begin
        a_new_s  = a_add_s;
        n_new_s  = n_act_s + N_length'(1);
        nn_new_s = nn_inc_s;
        if (halve_s) begin
            a_new_s  = a_add_s >> 1;
            n_new_s  = (n_act_s >> 1) + N_length'(1);
            nn_new_s = nn_inc_s >> 1;
        end else begin
            a_new_s  = a_add_s;
            n_new_s  = n_act_s + N_length'(1);
            nn_new_s = nn_inc_s;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE:     state_next_s = (ri_start && (mode == mode_length'(2))) ? ST_SELECT : ST_IDLE;
            ST_SELECT:   state_next_s = ST_K_SEARCH;
            ST_K_SEARCH: state_next_s = k_done_s ? ST_WAIT_ERR : ST_K_SEARCH;
            ST_WAIT_ERR: state_next_s = err_valid ? ST_UPDATE : ST_WAIT_ERR;
            ST_UPDATE:   state_next_s = ST_IDLE;
            default:     state_next_s = ST_IDLE;
        endcase
    end

    // FSM outputs, decoded one cycle ahead so the strobes come out of flops
    always_comb begin
        busy_s        = (state_next_s != ST_IDLE);
        k_valid_s     = (state_r == ST_K_SEARCH) && (state_next_s == ST_WAIT_ERR);
        emerr_valid_s = (state_next_s == ST_UPDATE);
        capture_s     = (state_r == ST_IDLE) && (state_next_s == ST_SELECT);
        err_take_s    = (state_r == ST_WAIT_ERR) && err_valid;
        ctx_upd_s     = (state_r == ST_UPDATE);
    end

    // Per-run datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            type_r        <= 1'b0;
            temp_r        <= {temp_length{1'b0}};
            k_r           <= {k_length{1'b0}};
            k_valid_r     <= 1'b0;
            emerr_valid_r <= 1'b0;
            busy_r        <= 1'b0;
            emerrval_r    <= {EW{1'b0}};
            map_r         <= 1'b0;
            err_neg_r     <= 1'b0;
        end else begin
            busy_r        <= busy_s;
            k_valid_r     <= k_valid_s;
            emerr_valid_r <= emerr_valid_s;
            if (capture_s) begin
                type_r <= ri_type;
            end
            if (state_r == ST_SELECT) begin
                temp_r <= temp_sel_s;
                k_r    <= {k_length{1'b0}};
            end else if (state_r == ST_K_SEARCH) begin
                k_r <= k_next_s;
            end
            if (err_take_s) begin
                emerrval_r <= emerr_s;
                map_r      <= map_s;
                err_neg_r  <= err_neg_s;
            end
        end
    end

    // Context storage; only the selected context is written, and only in UPDATE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r[0]  <= A_length'(A_INIT);
            a_r[1]  <= A_length'(A_INIT);
            n_r[0]  <= N_length'(1);
            n_r[1]  <= N_length'(1);
            nn_r[0] <= {N_length{1'b0}};
            nn_r[1] <= {N_length{1'b0}};
        end else if (ctx_upd_s) begin
            a_r[type_r]  <= a_new_s;
            n_r[type_r]  <= n_new_s;
            nn_r[type_r] <= nn_new_s;
        end
    end

    assign busy        = busy_r;
    assign temp        = temp_r;
    assign k_valid     = k_valid_r;
    assign k           = k_r;
    assign emerr_valid = emerr_valid_r;
    assign emerrval    = emerrval_r;
    assign map_bit     = map_r;

endmodule

// File: tb/tb_ri_context_sequencer.sv
// Scoreboard bench for ri_context_sequencer: a context model predicts temp/k/latency and map/EMErrval per run.
module tb_ri_context_sequencer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  mode;
    logic        ri_start;
    logic        ri_type;
    logic        busy;
    logic [16:0] temp;
    logic        k_valid;
    logic [4:0]  k;
    logic        err_valid;
    logic [8:0]  errval;
    logic        emerr_valid;
    logic [9:0]  emerrval;
    logic        map_bit;

    ri_context_sequencer dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .ri_start(ri_start), .ri_type(ri_type),
        .busy(busy), .temp(temp), .k_valid(k_valid), .k(k), .err_valid(err_valid),
        .errval(errval), .emerr_valid(emerr_valid), .emerrval(emerrval), .map_bit(map_bit)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;

    // Free-running cycle count used to time k_valid against the accepted start
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int t; int kk; int at; } kexp_t;
    typedef struct { int m; int em; } eexp_t;
    kexp_t kq[$];
    eexp_t eq[$];

    int ma [2];
    int mn [2];
    int mnn[2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            ma[i] = 4; mn[i] = 1; mnn[i] = 0;
        end
    endtask

    task automatic predict_k(input int rt, output int t, output int kk);
        t  = (rt == 1) ? ma[rt] + mn[rt] / 2 : ma[rt];
        kk = 0;
        while ((mn[rt] << kk) < t && kk < 31) kk++;
    endtask

    task automatic predict_err(input int rt, input int kk, input int e, output int m, output int em);
        int mag;
        mag = (e < 0) ? -e : e;
        m = ((kk == 0 && e > 0 && 2 * mnn[rt] < mn[rt]) || (e < 0 && 2 * mnn[rt] >= mn[rt])
             || (e < 0 && kk != 0)) ? 1 : 0;
        em = 2 * mag - rt - m;
        if (e < 0) mnn[rt]++;
        ma[rt] += (em + 1 - rt) / 2;
        if (ma[rt] > 65535) ma[rt] = 65535;
        if (mn[rt] == 64) begin
            ma[rt] /= 2; mn[rt] /= 2; mnn[rt] /= 2;
        end
        mn[rt]++;
    endtask

    function automatic int latency(input int kk);
`ifdef RI_KFAST_EN
        return 2;
`else
        return kk + 2;
`endif
    endfunction

    // Monitor: pop expectations whenever the DUT strobes a result
    always @(negedge clk) begin
        kexp_t x;
        eexp_t y;
        if (rst_n && k_valid) begin
            if (kq.size() == 0) check_eq("k_valid_unexpected", 32'd1, 32'd0);
            else begin
                x = kq.pop_front();
                check_eq("temp", 32'(temp), x.t);
                check_eq("k", 32'(k), x.kk);
                check_eq("k_valid_cycle", cyc, x.at);
                check_eq("busy_at_k", 32'(busy), 32'd1);
            end
        end
        if (rst_n && emerr_valid) begin
            if (eq.size() == 0) check_eq("emerr_valid_unexpected", 32'd1, 32'd0);
            else begin
                y = eq.pop_front();
                check_eq("map_bit", 32'(map_bit), y.m);
                check_eq("emerrval", 32'(emerrval), y.em);
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        kq.delete();
        eq.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic start_run(input int rt, input bit stray, output int kk);
        int t;
        int i;
        predict_k(rt, t, kk);
        @(negedge clk);
        mode = 2'd2; ri_type = rt[0]; ri_start = 1'b1;
        kq.push_back('{t, kk, cyc + 1 + latency(kk)});
        @(negedge clk);
        ri_start = 1'b0;
        if (stray) begin
            err_valid = 1'b1; errval = 9'd5;
            repeat (2) @(negedge clk);
            err_valid = 1'b0;
        end
        i = 0;
        while (!k_valid && i < 80) begin
            @(negedge clk);
            i++;
        end
        if (!k_valid) begin
            check_eq("k_valid_timeout", 32'd0, 32'd1);
            kq.delete();
        end
    endtask

    task automatic run(input int rt, input int e, input bit stray = 1'b0);
        int kk, m, em, i;
        start_run(rt, stray, kk);
        predict_err(rt, kk, e, m, em);
        eq.push_back('{m, em});
        errval = 9'(e); err_valid = 1'b1;
        @(negedge clk);
        err_valid = 1'b0;
        i = 0;
        while (!emerr_valid && i < 10) begin
            @(negedge clk);
            i++;
        end
        if (!emerr_valid) begin
            check_eq("emerr_valid_timeout", 32'd0, 32'd1);
            eq.delete();
        end
        @(negedge clk);
        check_eq("busy_after_run", 32'(busy), 32'd0);
    endtask

    initial begin
        int kk, rt, e;
        mode = 2'd0; ri_start = 1'b0; ri_type = 1'b0; err_valid = 1'b0; errval = 9'd0; rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_k", 32'(k), 32'd0);
        check_eq("rst_temp", 32'(temp), 32'd0);
        check_eq("rst_emerrval", 32'(emerrval), 32'd0);
        check_eq("rst_map", 32'(map_bit), 32'd0);
        check_eq("rst_k_valid", 32'(k_valid), 32'd0);
        check_eq("rst_emerr_valid", 32'(emerr_valid), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic runs: ctx365 then ctx366 isolation, negative errval, A=7 visible in temp
        run(0, 1);
        do_reset();
        run(1, 2);
        run(0, -3);
        run(0, 4);
        run(1, -1);

        // Starts outside run mode are ignored
        do_reset();
        @(negedge clk);
        mode = 2'd1; ri_start = 1'b1;
        @(negedge clk);
        ri_start = 1'b0;
        check_eq("mode1_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check_eq("mode1_busy_late", 32'(busy), 32'd0);

        // err_valid during SELECT/K_SEARCH is ignored
        run(0, 2, 1'b1);

        // Reset while waiting for Errval restores both contexts
        run(1, 3);
        start_run(0, 1'b0, kk);
        rst_n = 1'b0;
        #1;
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_k", 32'(k), 32'd0);
        check_eq("abort_temp", 32'(temp), 32'd0);
        do_reset();
        run(0, 1);
        run(1, 2);

        // N threshold halving on ctx365
        do_reset();
        for (int i = 0; i < 64; i++) run(0, 1);
        run(0, -2);
        run(1, 5);
        run(0, 3);

        // Mixed random traffic
        for (int i = 0; i < 40; i++) begin
            rt = int'($urandom_range(1, 0));
            e  = int'($urandom_range(240, 0)) - 120;
            if (rt == 1 && e == 0) e = 7;
            run(rt, e);
        end

        check_eq("kq_drained", 32'(kq.size()), 32'd0);
        check_eq("eq_drained", 32'(eq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
